// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit -- upstream control stage of the Project B processor.
//
// Holds the program counter and instruction register. Fetches 16-bit words
// from a synchronous (registered) instruction ROM, decodes them, and runs a
// Moore FSM that drives every DataPath control input.
//
// Instruction set (IR[15:12] = opcode):
//   NOOP 0000 | STORE 0001 D[IR11:8] <= RF[IR7:4] | LOAD 0010 RF[IR3:0] <= D[IR11:8]
//   ADD  0011 RF[IR3:0] <= RF[IR11:8] + RF[IR7:4]
//   SUB  0100 RF[IR3:0] <= RF[IR11:8] - RF[IR7:4]  | HALT 0101
//
// Build option:
//   CU_ILLEGAL_HALT_EN  defined   : opcodes 0110-1111 send the FSM to HALT
//                                   (IR_out keeps the offending word).
//                       undefined : opcodes 0110-1111 execute as NOOP.
//
// Ports:
//   clk, rst_n    clock / asynchronous active-low reset
//   I_Data        instruction ROM q (valid one cycle after I_Addr)
//   I_Addr        instruction ROM address (= PC)
//   D_Addr        data-memory address          D_WriteEn   data-memory write enable
//   MuxS          RF write-data select (1 = memory, 0 = ALU)
//   RegF_W_addr   RF write address             RegF_W_en   RF write enable
//   RegF_Ra_addr  RF read port A address       RegF_Rb_addr RF read port B address
//   ALU_S         ALU select (000 pass-A, 001 ADD, 010 SUB)
//   PC_out, IR_out, State_out   debug views of PC, IR and FSM state
//   Halted        high while the FSM sits in HALT
// -----------------------------------------------------------------------------
module control_unit #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     I_Data,
  output logic [PC_W-1:0] I_Addr,
  output logic [3:0]      D_Addr,
  output logic            D_WriteEn,
  output logic            MuxS,
  output logic [3:0]      RegF_W_addr,
  output logic            RegF_W_en,
  output logic [3:0]      RegF_Ra_addr,
  output logic [3:0]      RegF_Rb_addr,
  output logic [2:0]      ALU_S,
  output logic [PC_W-1:0] PC_out,
  output logic [15:0]     IR_out,
  output logic [3:0]      State_out,
  output logic            Halted
);

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b001;
  localparam logic [2:0] ALU_SUB    = 3'b010;

  // INIT is encoded as 0 so every output reads 0 while reset is held.
  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD_A = 4'd3,
    S_LOAD_B = 4'd4,
    S_STORE  = 4'd5,
    S_ADD    = 4'd6,
    S_SUB    = 4'd7,
    S_NOOP   = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; the async reset clears them at once,
  // which aborts an instruction and drops its write enable in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state and Moore control outputs (enables/selects depend on state only).
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    D_WriteEn = 1'b0;
    MuxS      = 1'b0;
    RegF_W_en = 1'b0;
    ALU_S     = ALU_PASS_A;

    case (state_q)
      S_INIT: begin
        pc_d    = '0;
        ir_d    = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        pc_d    = pc_q + PC_W'(1);   // wraps naturally at 2**PC_W
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // ROM q now holds the word addressed during FETCH; IR is not loaded
        // yet, so decode straight from I_Data.
        ir_d = I_Data;
        case (I_Data[15:12])
          OP_NOOP:  state_d = S_NOOP;
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default: begin
`ifdef CU_ILLEGAL_HALT_EN
            state_d = S_HALT;
`else
            state_d = S_NOOP;
`endif
          end
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;   // memory read in flight
      S_LOAD_B: begin
        MuxS      = 1'b1;
        RegF_W_en = 1'b1;
        state_d   = S_FETCH;
      end
      S_STORE: begin
        D_WriteEn = 1'b1;
        ALU_S     = ALU_PASS_A;       // write data is ALU_A = RF[Ra]
        state_d   = S_FETCH;
      end
      S_ADD: begin
        ALU_S     = ALU_ADD;
        RegF_W_en = 1'b1;
        state_d   = S_FETCH;
      end
      S_SUB: begin
        ALU_S     = ALU_SUB;
        RegF_W_en = 1'b1;
        state_d   = S_FETCH;
      end
      S_NOOP:  state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;      // only reset leaves HALT
      default: state_d = S_INIT;
    endcase
  end

  // Address outputs come from IR alone, so they are stable for the whole
  // execution of an instruction; fields unused by an opcode read as 0.
  always_comb begin
    D_Addr       = 4'd0;
    RegF_Ra_addr = 4'd0;
    RegF_Rb_addr = 4'd0;
    case (ir_q[15:12])
      OP_STORE: begin
        D_Addr       = ir_q[11:8];
        RegF_Ra_addr = ir_q[7:4];
      end
      OP_LOAD: D_Addr = ir_q[11:8];
      OP_ADD, OP_SUB: begin
        RegF_Ra_addr = ir_q[11:8];
        RegF_Rb_addr = ir_q[7:4];
      end
      default: ;
    endcase
  end

  assign RegF_W_addr = ir_q[3:0];
  assign I_Addr      = pc_q;
  assign PC_out      = pc_q;
  assign IR_out      = ir_q;
  assign State_out   = state_q;
  assign Halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit -- self-checking bench for control_unit (PC_W = 7).
// Surrounds the DUT with a registered instruction ROM and a small DataPath
// (register file, data memory, ALU). Expected results come from vector tables,
// hand-written sequences and an instruction-level interpreter.
// -----------------------------------------------------------------------------
module tb_control_unit;

  localparam int PC_W  = 7;
  localparam int DEPTH = 1 << PC_W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [15:0]     i_data;
  logic [PC_W-1:0] i_addr;
  logic [3:0]      d_addr;
  logic            d_we;
  logic            mux_s;
  logic [3:0]      w_addr;
  logic            rf_we;
  logic [3:0]      ra_addr;
  logic [3:0]      rb_addr;
  logic [2:0]      alu_s;
  logic [PC_W-1:0] pc_out;
  logic [15:0]     ir_out;
  logic [3:0]      state_out;
  logic            halted;

  control_unit #(.PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .I_Data(i_data), .I_Addr(i_addr),
    .D_Addr(d_addr), .D_WriteEn(d_we), .MuxS(mux_s),
    .RegF_W_addr(w_addr), .RegF_W_en(rf_we),
    .RegF_Ra_addr(ra_addr), .RegF_Rb_addr(rb_addr), .ALU_S(alu_s),
    .PC_out(pc_out), .IR_out(ir_out), .State_out(state_out), .Halted(halted)
  );

  always #5 clk = ~clk;

  // ---------------- environment: ROM and DataPath ----------------
  logic [15:0] rom     [DEPTH];
  logic [15:0] rf      [16];
  logic [15:0] dm      [16];
  logic [15:0] rf_init [16];
  logic [15:0] dm_init [16];
  logic        load_dp = 1'b0;
  logic [15:0] alu_out;

  always @(posedge clk) i_data <= rom[i_addr];

  always_comb begin
    alu_out = rf[ra_addr];
    case (alu_s)
      3'b001:  alu_out = rf[ra_addr] + rf[rb_addr];
      3'b010:  alu_out = rf[ra_addr] - rf[rb_addr];
      default: alu_out = rf[ra_addr];
    endcase
  end

  always @(posedge clk) begin
    if (load_dp) begin
      rf <= rf_init;
      dm <= dm_init;
    end else begin
      if (d_we)  dm[d_addr] <= rf[ra_addr];
      if (rf_we) rf[w_addr] <= mux_s ? dm[d_addr] : alu_out;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {7'(i_addr), d_addr, d_we, mux_s, w_addr, rf_we, ra_addr, rb_addr,
            alu_s, 7'(pc_out), ir_out, state_out, halted};
  endfunction

  // Hold reset, preload the DataPath, check the reset image, release on a
  // falling edge so the first rising edge moves INIT -> FETCH.
  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    load_dp = 1'b1;
    @(negedge clk);
    load_dp = 1'b0;
    check("reset_outputs_zero", all_outs(), 64'd0);
    rst_n = 1'b1;
  endtask

  // Run statistics captured by run_prog (k = rising edges since release).
  int          halt_k;
  int          d_we_cnt, rf_we_cnt;
  logic        mux_seen;
  logic [2:0]  alu_seen;
  logic [3:0]  s_d, s_ra, s_rb, s_w;
  logic [15:0] s_ir;
  logic [PC_W-1:0] s_pc;

  task automatic run_prog(input int max_k);
    halt_k = -1; d_we_cnt = 0; rf_we_cnt = 0; mux_seen = 1'b0; alu_seen = 3'd0;
    apply_reset();
    for (int k = 1; k <= max_k; k++) begin
      @(negedge clk);
      if (k == 3) begin
        s_d = d_addr; s_ra = ra_addr; s_rb = rb_addr; s_w = w_addr;
        s_ir = ir_out; s_pc = pc_out;
      end
      d_we_cnt  += int'(d_we);
      rf_we_cnt += int'(rf_we);
      mux_seen  |= mux_s;
      alu_seen  |= alu_s;
      if (halted) begin
        halt_k = k;
        break;
      end
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  logic [15:0]     exp_rf [16];
  logic [15:0]     exp_dm [16];
  int              exp_halt_k;
  logic [PC_W-1:0] exp_pc;
  logic [15:0]     exp_ir;

  task automatic ref_run();
    int   cyc;
    logic [15:0] w;
    exp_rf = rf_init;
    exp_dm = dm_init;
    cyc    = 0;
    exp_halt_k = -1;
    for (int i = 0; i < DEPTH; i++) begin
      w = rom[i];
      case (w[15:12])
        4'h0: cyc += 3;
        4'h1: begin exp_dm[w[11:8]] = exp_rf[w[7:4]]; cyc += 3; end
        4'h2: begin exp_rf[w[3:0]] = exp_dm[w[11:8]]; cyc += 4; end
        4'h3: begin exp_rf[w[3:0]] = exp_rf[w[11:8]] + exp_rf[w[7:4]]; cyc += 3; end
        4'h4: begin exp_rf[w[3:0]] = exp_rf[w[11:8]] - exp_rf[w[7:4]]; cyc += 3; end
        4'h5: begin cyc += 2; exp_halt_k = 1 + cyc; end
        default: begin
`ifdef CU_ILLEGAL_HALT_EN
          cyc += 2; exp_halt_k = 1 + cyc;
`else
          cyc += 3;
`endif
        end
      endcase
      if (exp_halt_k >= 0) begin
        exp_pc = PC_W'((i + 1) % DEPTH);
        exp_ir = w;
        break;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] instr;
    int          halt_k;
    int          d_we;
    int          rf_we;
    logic        mux;
    logic [2:0]  alu;
    logic [3:0]  d_a, ra, rb, w;
  } vec_t;

  vec_t vecs [8];

`ifdef CU_ILLEGAL_HALT_EN
  localparam int ILL_HALT_K = 3;
`else
  localparam int ILL_HALT_K = 6;
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic [PC_W-1:0] prev;
    logic ok;
    rst_n = 1'b0;

    vecs[0] = '{16'h0000, 6, 0, 0, 1'b0, 3'd0, 4'd0,  4'd0, 4'd0, 4'd0};
    vecs[1] = '{16'h1640, 6, 1, 0, 1'b0, 3'd0, 4'd6,  4'd4, 4'd0, 4'd0};
    vecs[2] = '{16'h2A03, 7, 0, 1, 1'b1, 3'd0, 4'd10, 4'd0, 4'd0, 4'd3};
    vecs[3] = '{16'h3124, 6, 0, 1, 1'b0, 3'd1, 4'd0,  4'd1, 4'd2, 4'd4};
    vecs[4] = '{16'h4125, 6, 0, 1, 1'b0, 3'd2, 4'd0,  4'd1, 4'd2, 4'd5};
    vecs[5] = '{16'h5000, 3, 0, 0, 1'b0, 3'd0, 4'd0,  4'd0, 4'd0, 4'd0};
    vecs[6] = '{16'h7000, ILL_HALT_K, 0, 0, 1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    vecs[7] = '{16'hF123, ILL_HALT_K, 0, 0, 1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 4'd3};

    for (int i = 0; i < 16; i++) begin rf_init[i] = 16'(i * 3); dm_init[i] = 16'(i + 100); end

    // ---- single-instruction vectors ----
    for (int v = 0; v < 8; v++) begin
      for (int a = 0; a < DEPTH; a++) rom[a] = 16'h5000;
      rom[0] = vecs[v].instr;
      run_prog(50);
      check($sformatf("v%0d_halt_cycle", v), 64'(halt_k), 64'(vecs[v].halt_k));
      check($sformatf("v%0d_ir", v), 64'(s_ir), 64'(vecs[v].instr));
      check($sformatf("v%0d_pc", v), 64'(s_pc), 64'd1);
      check($sformatf("v%0d_addrs", v), {48'd0, s_d, s_ra, s_rb, s_w},
            {48'd0, vecs[v].d_a, vecs[v].ra, vecs[v].rb, vecs[v].w});
      check($sformatf("v%0d_we_counts", v), {32'(d_we_cnt), 32'(rf_we_cnt)},
            {32'(vecs[v].d_we), 32'(vecs[v].rf_we)});
      check($sformatf("v%0d_mux_alu", v), {60'd0, mux_seen, alu_seen},
            {60'd0, vecs[v].mux, vecs[v].alu});
    end
`ifdef CU_ILLEGAL_HALT_EN
    check("illegal_ir_held", 64'(ir_out), 64'hF123);
`endif

    // ---- LOAD / ADD / SUB / STORE sequence ----
    for (int i = 0; i < 16; i++) begin rf_init[i] = 16'd0; dm_init[i] = 16'd0; end
    dm_init[10] = 16'h1234; rf_init[1] = 16'd5; rf_init[2] = 16'd7;
    for (int a = 0; a < DEPTH; a++) rom[a] = 16'h5000;
    rom[0] = 16'h2A03; rom[1] = 16'h3124; rom[2] = 16'h4125; rom[3] = 16'h1640;
    run_prog(60);
    check("seq_halt_cycle", 64'(halt_k), 64'd16);
    check("seq_rf3_load",   64'(rf[3]), 64'h1234);
    check("seq_rf4_add",    64'(rf[4]), 64'd12);
    check("seq_rf5_sub",    64'(rf[5]), 64'hFFFE);
    check("seq_dm6_store",  64'(dm[6]), 64'd12);
    check("seq_store_once", 64'(d_we_cnt), 64'd1);

    // ---- reset mid-ADD ----
    rf_init[4] = 16'hAAAA;
    for (int a = 0; a < DEPTH; a++) rom[a] = 16'h5000;
    rom[0] = 16'h3124;
    apply_reset();
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      ok = rf_we;
    end
    check("rst_reached_add", 64'(ok), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_we_drops",   64'(rf_we), 64'd0);
    check("rst_all_zero",   all_outs(), 64'd0);
    @(posedge clk); #1;
    check("rst_rf4_untouched", 64'(rf[4]), 64'hAAAA);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_k1_pc", 64'(pc_out), 64'd0);
    @(negedge clk);
    check("rst_k2_fetched", 64'(pc_out), 64'd1);

    // ---- HALT at the last address: PC wraps, HALT holds ----
    for (int a = 0; a < DEPTH; a++) rom[a] = 16'h0000;
    rom[DEPTH-1] = 16'h5000;
    run_prog(1000);
    check("wrap_halt_cycle", 64'(halt_k), 64'(1 + (DEPTH - 1) * 3 + 2));
    check("wrap_halt_pc",    64'(pc_out), 64'd0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (halted && pc_out == '0) cnt++;
    end
    check("halt_holds_20", 64'(cnt), 64'd20);

    // ---- all NOOPs: PC wraps last -> 0 and keeps going ----
    rom[DEPTH-1] = 16'h0000;
    apply_reset();
    ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      ok = (pc_out == PC_W'(DEPTH - 1));
    end
    check("nowrap_reached_last", 64'(ok), 64'd1);
    for (int step = 0; step < 2; step++) begin
      prev = pc_out;
      for (int k = 0; k < 10 && pc_out == prev; k++) @(negedge clk);
      check($sformatf("nowrap_pc_step%0d", step), {63'd0, halted, 7'(pc_out)} , 64'(step));
    end

    // ---- randomized programs vs. interpreter ----
    for (int p = 0; p < 8; p++) begin
      logic [3:0] op;
      for (int i = 0; i < 16; i++) begin
        rf_init[i] = 16'($urandom);
        dm_init[i] = 16'($urandom);
      end
      for (int a = 0; a < DEPTH; a++) rom[a] = 16'h5000;
      for (int a = 0; a < 20; a++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'h5) op = 4'h3;
        rom[a] = {op, 12'($urandom)};
      end
      ref_run();
      run_prog(300);
      check($sformatf("rnd%0d_halt_cycle", p), 64'(halt_k), 64'(exp_halt_k));
      check($sformatf("rnd%0d_pc", p), 64'(pc_out), 64'(exp_pc));
      check($sformatf("rnd%0d_ir", p), 64'(ir_out), 64'(exp_ir));
      for (int r = 0; r < 16; r++) begin
        check($sformatf("rnd%0d_rf%0d", p, r), 64'(rf[r]), 64'(exp_rf[r]));
        check($sformatf("rnd%0d_dm%0d", p, r), 64'(dm[r]), 64'(exp_dm[r]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
